// File: rtl/pov_pkg.sv
// Shared widths, reset POV and field offsets for the POV SPI receiver.
// Field order inside the POV vector, MSB first: player_x, player_y, facing_x/y, vplane_x/y.
package pov_pkg;

    localparam int unsigned PW       = 15;
    localparam int unsigned VW       = 11;
    localparam int unsigned POV_BITS = 2 * PW + 4 * VW;

    // Bit counter must hold POV_BITS+1 (saturation value).
    localparam int unsigned CNT_W = $clog2(POV_BITS + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(POV_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(POV_BITS + 1);

    localparam int unsigned OFF_VY = 0;
    localparam int unsigned OFF_VX = VW;
    localparam int unsigned OFF_FY = 2 * VW;
    localparam int unsigned OFF_FX = 3 * VW;
    localparam int unsigned OFF_PY = 4 * VW;
    localparam int unsigned OFF_PX = 4 * VW + PW;

    localparam logic [PW-1:0] RST_PLAYER_X = 15'h0300;
    localparam logic [PW-1:0] RST_PLAYER_Y = 15'h0300;
    localparam logic [VW-1:0] RST_FACING_X = 11'h000;
    localparam logic [VW-1:0] RST_FACING_Y = 11'h200;
    localparam logic [VW-1:0] RST_VPLANE_X = 11'h100;
    localparam logic [VW-1:0] RST_VPLANE_Y = 11'h000;

    localparam logic [POV_BITS-1:0] RST_POV = {RST_PLAYER_X, RST_PLAYER_Y,
                                               RST_FACING_X, RST_FACING_Y,
                                               RST_VPLANE_X, RST_VPLANE_Y};

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StEnd
    } rx_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus one delay stage for edge detection.
module sync_edge #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {3{ResetVal}};
        end else begin
            sync_q <= {sync_q[1:0], i_d};
        end
    end

    assign o_level = sync_q[1];
    assign o_rise  = sync_q[1] & ~sync_q[2];
    assign o_fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/pov_spi_rx.sv
// POV vector SPI receiver: oversampled mode-0 SPI into a shadow buffer, swapped in on i_load.
// Optional macro RBZ_POV_INC_EN: i_load with nothing pending nudges player X/Y by i_inc_px/py.
module pov_spi_rx
    import pov_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_sclk,
    input  logic          i_mosi,
    input  logic          i_ss_n,
    input  logic          i_load,
    input  logic          i_inc_px,
    input  logic          i_inc_py,
    output logic [PW-1:0] o_player_x,
    output logic [PW-1:0] o_player_y,
    output logic [VW-1:0] o_facing_x,
    output logic [VW-1:0] o_facing_y,
    output logic [VW-1:0] o_vplane_x,
    output logic [VW-1:0] o_vplane_y,
    output logic          o_pending,
    output logic          o_err
);

    logic sclk_rise, ss_rise, ss_fall, mosi_s;
    logic sclk_unused_level, sclk_unused_fall;
    logic mosi_unused_rise, mosi_unused_fall;
    logic ss_unused_level;

    sync_edge #(.ResetVal(1'b0)) u_sync_sclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (i_sclk),
        .o_level (sclk_unused_level),
        .o_rise  (sclk_rise),
        .o_fall  (sclk_unused_fall)
    );

    sync_edge #(.ResetVal(1'b0)) u_sync_mosi (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (i_mosi),
        .o_level (mosi_s),
        .o_rise  (mosi_unused_rise),
        .o_fall  (mosi_unused_fall)
    );

    // Select idles high, so reset to 1 to avoid a spurious fall after reset.
    sync_edge #(.ResetVal(1'b1)) u_sync_ss (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (i_ss_n),
        .o_level (ss_unused_level),
        .o_rise  (ss_rise),
        .o_fall  (ss_fall)
    );

`ifdef RBZ_POV_INC_EN
    logic [1:0] inc_px_q, inc_py_q;
    logic       inc_px_s, inc_py_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_px_q <= 2'b00;
            inc_py_q <= 2'b00;
        end else begin
            inc_px_q <= {inc_px_q[0], i_inc_px};
            inc_py_q <= {inc_py_q[0], i_inc_py};
        end
    end

    assign inc_px_s = inc_px_q[1];
    assign inc_py_s = inc_py_q[1];
`else
    logic unused_inc;
    assign unused_inc = i_inc_px ^ i_inc_py;
`endif

    rx_state_e           state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [POV_BITS-1:0] shift_q, shift_d;
    logic [POV_BITS-1:0] shadow_q, shadow_d;
    logic [POV_BITS-1:0] act_q, act_d;
    logic                pending_q, pending_d;
    logic                err_q, err_d;
    logic                commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            shift_q   <= '0;
            shadow_q  <= RST_POV;
            act_q     <= RST_POV;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            shadow_q  <= shadow_d;
            act_q     <= act_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shift_d   = shift_q;
        shadow_d  = shadow_q;
        act_d     = act_q;
        pending_d = pending_q;
        err_d     = 1'b0;
        commit    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ss_fall) begin
                    state_d = StShift;
                    count_d = '0;
                end
            end
            StShift: begin
                if (sclk_rise) begin
                    shift_d = {shift_q[POV_BITS-2:0], mosi_s};
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                if (ss_rise) begin
                    state_d = StEnd;
                end
            end
            // One registered cycle after the select rise to judge the frame length.
            StEnd: begin
                if (count_q == CNT_FULL) begin
                    commit = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                if (ss_fall) begin
                    state_d = StShift;
                    count_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (i_load) begin
            if (pending_q) begin
                act_d     = shadow_q;
                pending_d = 1'b0;
            end
`ifdef RBZ_POV_INC_EN
            else begin
                act_d[OFF_PX +: PW] = act_q[OFF_PX +: PW] + PW'(inc_px_s);
                act_d[OFF_PY +: PW] = act_q[OFF_PY +: PW] + PW'(inc_py_s);
            end
`endif
        end

        // Applied after the load so a coincident frame lands in the shadow and stays pending.
        if (commit) begin
            shadow_d  = shift_q;
            pending_d = 1'b1;
        end
    end

    assign o_player_x = act_q[OFF_PX +: PW];
    assign o_player_y = act_q[OFF_PY +: PW];
    assign o_facing_x = act_q[OFF_FX +: VW];
    assign o_facing_y = act_q[OFF_FY +: VW];
    assign o_vplane_x = act_q[OFF_VX +: VW];
    assign o_vplane_y = act_q[OFF_VY +: VW];
    assign o_pending  = pending_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_pov_spi_rx.sv
// Scoreboard bench for pov_spi_rx: drivers push expected output snapshots, a monitor pops them.
`timescale 1ns/1ps
module tb_pov_spi_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic ss_n = 1'b1;
    logic load = 1'b0;
    logic inc_px = 1'b0;
    logic inc_py = 1'b0;

    logic [14:0] player_x, player_y;
    logic [10:0] facing_x, facing_y, vplane_x, vplane_y;
    logic        pending, err;

    pov_spi_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sclk     (sclk),
        .i_mosi     (mosi),
        .i_ss_n     (ss_n),
        .i_load     (load),
        .i_inc_px   (inc_px),
        .i_inc_py   (inc_py),
        .o_player_x (player_x),
        .o_player_y (player_y),
        .o_facing_x (facing_x),
        .o_facing_y (facing_y),
        .o_vplane_x (vplane_x),
        .o_vplane_y (vplane_y),
        .o_pending  (pending),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic        pend;
        logic [73:0] pov;
    } snap_t;

    typedef struct {
        snap_t s;
        string name;
    } exp_t;

    localparam logic [73:0] RST_POV = {15'h0300, 15'h0300, 11'h000, 11'h200, 11'h100, 11'h000};
    localparam logic [73:0] F1   = {15'h1234, 15'h0456, 11'h7FF, 11'h001, 11'h155, 11'h2AA};
    localparam logic [73:0] FA   = {15'h0A0A, 15'h0B0B, 11'h123, 11'h321, 11'h0F0, 11'h70F};
    localparam logic [73:0] FB   = {15'h5555, 15'h2AAA, 11'h3C3, 11'h43C, 11'h00F, 11'h7F0};
    localparam logic [73:0] PMAX = {15'h7FFF, 15'h0400, 11'h011, 11'h022, 11'h033, 11'h044};

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    logic [73:0] m_act = RST_POV;
    logic [73:0] m_shadow = RST_POV;
    logic        m_pend = 1'b0;

    function automatic snap_t dut_snap();
        return snap_t'({err, pending, player_x, player_y, facing_x, facing_y, vplane_x, vplane_y});
    endfunction

    task automatic push(input string name, input logic e);
        exp_t x;
        x.s    = snap_t'({e, m_pend, m_act});
        x.name = name;
        exp_q.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic spi_bit(input logic b);
        mosi = b;
        tick(2);
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
        tick(2);
    endtask

    task automatic send_frame(input string name, input logic [73:0] vec, input int nbits,
                              input bit lat_chk, input bit coinc);
        logic        old_pend;
        logic [73:0] old_act;
        int          lat;
        old_pend = m_pend;
        old_act  = m_act;
        if (nbits == 74) begin
            if (coinc && m_pend) m_act = m_shadow;
            m_shadow = vec;
            m_pend   = 1'b1;
            if (m_pend != old_pend || m_act != old_act) push(name, 1'b0);
        end else begin
            push(name, 1'b1);
        end
        ss_n = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            if (i < 74) spi_bit(vec[73-i]);
            else        spi_bit(1'b0);
        end
        tick(4);
        ss_n = 1'b1;
        if (coinc) begin
            // Commit lands on the 4th edge after the select rise; strobe load into that edge.
            tick(3);
            load = 1'b1;
            tick(1);
            load = 1'b0;
            tick(6);
        end else if (lat_chk) begin
            lat = 0;
            for (int c = 1; c <= 20 && lat == 0; c++) begin
                tick(1);
                if (pending) lat = c;
            end
            tests++;
            if (lat != 4) begin
                fails++;
                $display("FAIL %s_latency: got %0d cycles, required 4", name, lat);
            end
            tick(6);
        end else begin
            tick(10);
        end
    endtask

    task automatic do_load(input string name);
        logic        old_pend;
        logic [73:0] old_act;
        old_pend = m_pend;
        old_act  = m_act;
        if (m_pend) begin
            m_act  = m_shadow;
            m_pend = 1'b0;
        end
`ifdef RBZ_POV_INC_EN
        else begin
            m_act[73:59] = m_act[73:59] + 15'(inc_px);
            m_act[58:44] = m_act[58:44] + 15'(inc_py);
        end
`endif
        if (m_pend != old_pend || m_act != old_act) push(name, 1'b0);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(4);
    endtask

    // Monitor: any err pulse or change of pending/outputs is one DUT event to be matched.
    initial begin
        snap_t cur, prev;
        exp_t  e;
        bit    armed;
        armed = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                cur = dut_snap();
                if (!armed) begin
                    armed = 1'b1;
                end else if (cur.err || cur.pend != prev.pend || cur.pov != prev.pov) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_event: got err=%0b pend=%0b pov=%h, required no change",
                                 cur.err, cur.pend, cur.pov);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e.s) begin
                            fails++;
                            $display("FAIL %s: got err=%0b pend=%0b pov=%h, required err=%0b pend=%0b pov=%h",
                                     e.name, cur.err, cur.pend, cur.pov, e.s.err, e.s.pend, e.s.pov);
                        end
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        snap_t s;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        s = dut_snap();
        tests++;
        if (s !== snap_t'({1'b0, 1'b0, RST_POV})) begin
            fails++;
            $display("FAIL reset_state: got err=%0b pend=%0b pov=%h, required err=0 pend=0 pov=%h",
                     s.err, s.pend, s.pov, RST_POV);
        end
        mon_en = 1'b1;
        tick(2);

        send_frame("f1", F1, 74, 1'b1, 1'b0);
        tick(20);
        do_load("f1_load");

        send_frame("short73", FB, 73, 1'b0, 1'b0);
        send_frame("long75", FB, 75, 1'b0, 1'b0);
        do_load("load_after_bad");

        send_frame("a", FA, 74, 1'b1, 1'b0);
        send_frame("b", FB, 74, 1'b0, 1'b0);
        do_load("ab_load");

        send_frame("a2", FA, 74, 1'b1, 1'b0);
        send_frame("b_coinc", FB, 74, 1'b0, 1'b1);
        do_load("coinc_load");

        send_frame("pmax", PMAX, 74, 1'b1, 1'b0);
        do_load("pmax_load");
        inc_px = 1'b1;
        tick(4);
        do_load("inc_load");
        inc_px = 1'b0;
        tick(4);

        // Abort a frame partway with reset; everything returns to reset values.
        ss_n = 1'b0;
        tick(4);
        for (int i = 0; i < 30; i++) spi_bit(FA[73-i]);
        rst_n = 1'b0;
        ss_n  = 1'b1;
        mosi  = 1'b0;
        sclk  = 1'b0;
        begin
            logic [73:0] old_act;
            logic        old_pend;
            old_act  = m_act;
            old_pend = m_pend;
            m_act    = RST_POV;
            m_shadow = RST_POV;
            m_pend   = 1'b0;
            if (m_act != old_act || m_pend != old_pend) push("mid_reset", 1'b0);
        end
        tick(2);
        rst_n = 1'b1;
        tick(6);
        do_load("load_after_reset");

        send_frame("empty_select", F1, 0, 1'b0, 1'b0);
        send_frame("f1b", F1, 74, 1'b1, 1'b0);
        do_load("f1b_load");

        tick(10);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover_expected: got %0d unmatched events, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pov_spi_rx.md
Name: pov_spi_rx

Overview:
- Upstream stage of the raybox-zero renderer. Receives the point-of-view (POV) vector over the external SPI pins (pov_sclk, pov_mosi, pov_ss_n), which arrive on ui_in[2:0].
- Double-buffers the vector and presents it to the ray caster.
- The active POV changes only on a frame-start strobe, so a frame is never rendered with a half-updated view.
- SPI pins are asynchronous to clk and are oversampled in the clk domain.

Parameters:
- PW, 15: player position width (Q6.9 fixed point).
- VW, 11: facing/vplane component width (Q2.9 fixed point).
- POV_BITS, 2*PW+4*VW (=74): exact SPI frame length in bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_sclk  in  1  SPI clock (mode 0), asynchronous.
- i_mosi  in  1  SPI data, MSB first.
- i_ss_n  in  1  SPI select, active-low.
- i_load  in  1  one-cycle frame-start strobe (from vsync logic).
- i_inc_px  in  1  player-X nudge request, asynchronous.
- i_inc_py  in  1  player-Y nudge request, asynchronous.
- o_player_x  out  PW  active player X.
- o_player_y  out  PW  active player Y.
- o_facing_x  out  VW  active facing X.
- o_facing_y  out  VW  active facing Y.
- o_vplane_x  out  VW  active view-plane X.
- o_vplane_y  out  VW  active view-plane Y.
- o_pending  out  1  a complete frame is buffered and awaiting i_load.
- o_err  out  1  one-cycle pulse: a frame was rejected for wrong length.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n. All flops are reset.
- Reset values:
  - o_player_x = o_player_y = 15'h0300 (1.5).
  - o_facing_x = 0, o_facing_y = 11'h200 (1.0).
  - o_vplane_x = 11'h100 (0.5), o_vplane_y = 0.
  - The shadow buffer resets to the same values.
  - o_pending = 0, o_err = 0, bit count = 0.
- Synchronisation: i_sclk, i_mosi and i_ss_n each pass through a 2-FF synchroniser, plus one delay stage for edge detection. Supported rate: sclk period >= 4 clk periods.
- Receive states:
  - IDLE: ss_n high.
  - SHIFT: ss_n low. Entered on the ss_n falling edge; bit count cleared on entry.
  - In SHIFT, each synchronised sclk rising edge shifts mosi into the LSB of the POV_BITS shift register. The count increments and saturates at POV_BITS+1.
  - sclk edges while ss_n is high are ignored.
- Frame end (ss_n rising edge, SHIFT -> IDLE):
  - If count == POV_BITS: shadow <= shift register, o_pending <= 1.
  - Otherwise: shadow unchanged, o_err pulses high for 1 cycle.
  - Count 0 (empty select) also errors.
- Field order, MSB first: player_x, player_y, facing_x, facing_y, vplane_x, vplane_y.
- Load:
  - i_load with o_pending = 1: active outputs <= shadow on the next clk edge, o_pending <= 0.
  - i_load with o_pending = 0: active outputs hold, except as described under Optional Feature.
  - Latency from the ss_n pin rising to o_pending high: 4 clk cycles.
- Simultaneous frame completion and i_load in the same cycle:
  - Active outputs take the old shadow if it was pending, else they hold.
  - Shadow takes the new frame; o_pending ends at 1.
- A new frame arriving while o_pending = 1 overwrites the shadow; the last complete frame wins.
- Reset mid-frame discards the partial frame and returns all registers to reset values.

Optional Feature:
- Macro: RBZ_POV_INC_EN.
- When defined:
  - i_inc_px and i_inc_py are 2-FF synchronised.
  - On i_load with o_pending = 0: o_player_x += inc_px and o_player_y += inc_py, wrapping modulo 2^PW.
  - When o_pending = 1, the SPI load takes priority and no increment is applied.
- When undefined: both inputs are ignored (ports remain, unused). Outputs change only via SPI load or reset.

Decomposition:
- Shared package/header pov_pkg holds:
  - PW, VW, POV_BITS.
  - Reset constants for all six fields.
  - Field offset constants within the POV vector.
- One sub-module, sync_edge: 2-FF synchroniser plus delay stage, outputs level/rise/fall. Instantiated for sclk and ss_n; mosi uses its level output only.

Test Plan:
- Reset: assert rst_n = 0 mid-stream -> outputs = 0300/0300/000/200/100/000, o_pending = 0.
- Full frame: player_x=0x1234, player_y=0x0456, facing_x=0x7FF, facing_y=0x001, vplane_x=0x155, vplane_y=0x2AA -> o_pending = 1 four cycles after ss_n rises; outputs unchanged until i_load, then exactly those values, o_pending = 0.
- Short frame (73 bits) and long frame (75 bits) -> o_err pulses once each, o_pending stays 0, a later i_load leaves outputs unchanged.
- Two complete frames A then B before i_load -> outputs = B after i_load.
- Frame completion coincident with i_load while A is pending -> outputs = A, shadow = B, o_pending = 1.
- RBZ_POV_INC_EN defined, i_inc_px = 1, player_x = 0x7FFF, i_load with no pending -> player_x = 0x0000 and player_y unchanged. Macro undefined -> no change.
